// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes, and the
// ALU-op / datapath mux selects also consumed by the ALU control decoder.
package ctrl_pkg;

    // State encodings. StReset must stay at zero so state_dbg reads 0 in reset.
    // Codes 14 and 15 are unused and recover to StReset.
    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExec    = 4'd7,
        StRwb     = 4'd8,
        StOriExec = 4'd9,
        StIwb     = 4'd10,
        StBranch  = 4'd11,
        StJump    = 4'd12,
        StTrap    = 4'd13
    } state_t;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // alu_op, decoded further by the ALU control unit
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the two opcodes that go through the address-compute state
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS-subset core. Moore outputs from the
// state register; the only Mealy terms are ir_write/pc_write gated by mem_ready
// in FETCH so the IR and PC load exactly on the cycle the instruction arrives.
module multicycle_control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t state_q, state_d;

    // State register; async reset abandons any in-flight memory access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: opcode is only looked at in DECODE and MEMADDR
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                if (is_mem_op(opcode)) begin
                    state_d = StMemAddr;
                end else begin
                    case (opcode)
                        OP_RTYPE: state_d = StExec;
                        OP_BEQ:   state_d = StBranch;
                        OP_J:     state_d = StJump;
                        OP_ORI:   state_d = StOriExec;
                        default:  state_d = StTrap;
                    endcase
                end
            end
            StMemAddr: begin
                // IR is frozen, so anything but LW/SW here means corrupted state
                if (opcode == OP_LW) begin
                    state_d = StMemRd;
                end else if (opcode == OP_SW) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StTrap;
                end
            end
            StMemRd: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWr: begin
                if (mem_ready) state_d = StFetch;
            end
            StExec:    state_d = StRwb;
            StOriExec: state_d = StIwb;
            StMemWb,
            StRwb,
            StIwb,
            StBranch,
            StJump:    state_d = StFetch;
            StTrap:    state_d = StTrap;
            default:   state_d = StReset;
        endcase
    end

    // Output decode; everything defaults low so RESET/TRAP issue no requests
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        ext_zero      = 1'b0;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        case (state_q)
            StFetch: begin
                // PC + 4 computed every FETCH cycle, committed only on ready
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                // Speculative branch target into ALUOut
                alu_src_b = SRCB_IMM_SH;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            StRwb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StOriExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_zero  = 1'b1;
                alu_op    = ALU_OR;
            end
            StIwb: begin
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            StTrap: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a route-table reference model checks every
// output on every falling edge, plus table-driven instruction walks, hand-written
// wait/trap/reset sequences, and a randomized run.
module tb_multicycle_control_fsm;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    multicycle_control_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .ext_zero     (ext_zero),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal_op   (illegal_op),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } outs_t;

    // Control word each state is documented to drive
    function automatic outs_t expect_outs(input state_t s, input logic rdy);
        outs_t o;
        o = '0;
        case (s)
            StFetch: begin
                o.mem_read = 1; o.alu_src_b = 2'b01;
                o.ir_write = rdy; o.pc_write = rdy;
            end
            StDecode:  o.alu_src_b = 2'b11;
            StMemAddr: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            StMemRd:   begin o.mem_read = 1; o.i_or_d = 1; end
            StMemWb:   begin o.reg_write = 1; o.mem_to_reg = 1; end
            StMemWr:   begin o.mem_write = 1; o.i_or_d = 1; end
            StExec:    begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            StRwb:     begin o.reg_write = 1; o.reg_dst = 1; end
            StOriExec: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10; o.ext_zero = 1; o.alu_op = 2'b11;
            end
            StIwb:     o.reg_write = 1;
            StBranch:  begin
                o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01;
            end
            StJump:    begin o.pc_write = 1; o.pc_source = 2'b10; end
            StTrap:    o.illegal_op = 1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    // Reference model: after a fetch, the opcode selects a fixed route of states
    state_t ms = StReset;
    state_t plan[$];

    task automatic load_route(input logic [5:0] op);
        plan.delete();
        plan.push_back(StDecode);
        case (op)
            6'b100011: begin plan.push_back(StMemAddr); plan.push_back(StMemRd);
                             plan.push_back(StMemWb); end
            6'b101011: begin plan.push_back(StMemAddr); plan.push_back(StMemWr); end
            6'b000000: begin plan.push_back(StExec); plan.push_back(StRwb); end
            6'b001101: begin plan.push_back(StOriExec); plan.push_back(StIwb); end
            6'b000100: plan.push_back(StBranch);
            6'b000010: plan.push_back(StJump);
            default:   plan.push_back(StTrap);
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms = StReset;
            plan.delete();
        end else if (ms == StReset) begin
            ms = StFetch;
        end else if (ms == StTrap) begin
            ms = StTrap;
        end else if ((ms == StFetch || ms == StMemRd || ms == StMemWr) && !mem_ready) begin
            ms = ms;
        end else begin
            if (ms == StFetch) load_route(opcode);
            if (plan.size() == 0) ms = StFetch;
            else ms = plan.pop_front();
        end
    end

    outs_t got_o, exp_o;

    // Continuous comparison against the model on every falling edge
    always @(negedge clk) begin
        got_o = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op, pc_source,
                 illegal_op};
        exp_o = expect_outs(ms, mem_ready);
        n_checks++;
        if (got_o !== exp_o || state_dbg !== 4'(ms)) begin
            n_fail++;
            $display("FAIL model t=%0t state got %0d exp %0d outs got %h exp %h",
                     $time, state_dbg, ms, got_o, exp_o);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, exp);
        end
    endtask

    task automatic wait_state(input state_t s, input int budget);
        int k;
        k = 0;
        while (state_dbg !== 4'(s) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_state", {28'd0, state_dbg}, {28'd0, 4'(s)});
    endtask

    typedef struct packed {
        logic [5:0]      op;
        int unsigned     len;
        logic [4:0][3:0] path;
        int unsigned     key;
        logic [1:0]      key_alu;
    } vec_t;

    vec_t vecs[6];

    task automatic set_vec(input int i, input logic [5:0] op, input int unsigned len,
                           input state_t s2, input state_t s3, input state_t s4,
                           input int unsigned key, input logic [1:0] ka);
        vecs[i].op      = op;
        vecs[i].len     = len;
        vecs[i].path[0] = StFetch;
        vecs[i].path[1] = StDecode;
        vecs[i].path[2] = s2;
        vecs[i].path[3] = s3;
        vecs[i].path[4] = s4;
        vecs[i].key     = key;
        vecs[i].key_alu = ka;
    endtask

    function automatic logic [5:0] pick_op();
        int r;
        logic [5:0] v;
        r = $urandom_range(0, 19);
        if (r < 3) v = 6'b100011;
        else if (r < 6) v = 6'b101011;
        else if (r < 9) v = 6'b000000;
        else if (r < 12) v = 6'b000100;
        else if (r < 15) v = 6'b000010;
        else if (r < 18) v = 6'b001101;
        else v = 6'($urandom_range(0, 63));
        return v;
    endfunction

    initial begin
        int fetch_n, ir_n, ill_n, wr_n, trap_n;
        state_t lw_seq[6];

        set_vec(0, 6'b100011, 5, StMemAddr, StMemRd,  StMemWb, 2, 2'b00);
        set_vec(1, 6'b101011, 4, StMemAddr, StMemWr,  StFetch, 2, 2'b00);
        set_vec(2, 6'b000000, 4, StExec,    StRwb,    StFetch, 2, 2'b10);
        set_vec(3, 6'b001101, 4, StOriExec, StIwb,    StFetch, 2, 2'b11);
        set_vec(4, 6'b000100, 3, StBranch,  StFetch,  StFetch, 2, 2'b01);
        set_vec(5, 6'b000010, 3, StJump,    StFetch,  StFetch, 2, 2'b00);

        // Reset state
        #3;
        check("reset_state", {28'd0, state_dbg}, 32'd0);
        check("reset_mem_read", {31'd0, mem_read}, 32'd0);
        check("reset_pc_write", {31'd0, pc_write}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b100011;

        // LW walk from reset with zero wait states
        lw_seq = '{StReset, StFetch, StDecode, StMemAddr, StMemRd, StMemWb};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lw_path", {28'd0, state_dbg}, {28'd0, 4'(lw_seq[i])});
            check("lw_reg_write", {31'd0, reg_write}, {31'd0, lw_seq[i] == StMemWb});
            check("lw_mem_to_reg", {31'd0, mem_to_reg}, {31'd0, lw_seq[i] == StMemWb});
        end
        @(negedge clk);
        check("lw_back_fetch", {28'd0, state_dbg}, {28'd0, 4'(StFetch)});

        // Table: one instruction per record, latency and key alu_op
        for (int v = 0; v < 6; v++) begin
            opcode = vecs[v].op;
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                check("vec_path", {28'd0, state_dbg}, {28'd0, vecs[v].path[k]});
                if (k == int'(vecs[v].key))
                    check("vec_alu_op", {30'd0, alu_op}, {30'd0, vecs[v].key_alu});
                @(negedge clk);
            end
            check("vec_latency", {28'd0, state_dbg}, {28'd0, 4'(StFetch)});
        end

        // R-type with mem_ready low for three FETCH edges
        opcode = 6'b000000;
        #1;
        mem_ready = 1'b0;
        fetch_n = 1;
        ir_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) mem_ready = 1'b1;
            @(negedge clk);
            if (state_dbg == 4'(StFetch)) fetch_n++;
            if (ir_write) ir_n++;
        end
        check("rtype_fetch_cycles", fetch_n, 4);
        check("rtype_ir_pulses", ir_n, 1);
        @(negedge clk);
        check("rtype_decode", {28'd0, state_dbg}, {28'd0, 4'(StDecode)});
        @(negedge clk);
        check("rtype_exec_alu_op", {30'd0, alu_op}, 32'd2);
        @(negedge clk);
        check("rtype_rwb_reg_dst", {31'd0, reg_dst}, 32'd1);
        @(negedge clk);
        check("rtype_back_fetch", {28'd0, state_dbg}, {28'd0, 4'(StFetch)});

        // Illegal opcode: absorbing trap, cleared only by async reset
        opcode = 6'b111111;
        wait_state(StTrap, 5);
        ill_n = 0;
        wr_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (illegal_op) ill_n++;
            if (reg_write | mem_write | mem_read | pc_write | pc_write_cond | ir_write) wr_n++;
        end
        check("trap_illegal_held", ill_n, 20);
        check("trap_no_writes", wr_n, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("trap_async_clear", {31'd0, illegal_op}, 32'd0);
        check("trap_async_state", {28'd0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        opcode = 6'b101011;
        @(negedge clk);
        check("post_trap_reset", {28'd0, state_dbg}, {28'd0, 4'(StReset)});

        // SW stalled in MEMWR, then reset mid-access
        wait_state(StMemWr, 10);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_stall_state", {28'd0, state_dbg}, {28'd0, 4'(StMemWr)});
        check("sw_stall_write", {31'd0, mem_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_abort_write", {31'd0, mem_write}, 32'd0);
        check("sw_abort_state", {28'd0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("sw_release_reset", {28'd0, state_dbg}, {28'd0, 4'(StReset)});
        @(negedge clk);
        check("sw_release_fetch", {28'd0, state_dbg}, {28'd0, 4'(StFetch)});

        // Randomized traffic; the model checker compares every cycle
        trap_n = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else begin
                if (ms == StTrap) trap_n++;
                if (trap_n > 3 || $urandom_range(0, 199) == 0) begin
                    rst_n = 1'b0;
                    trap_n = 0;
                end
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            if (ms == StFetch) opcode = pick_op();
        end
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
